// File: rtl/simt_pc_if.sv
// Bundles the decoder/ALU/scheduler signals of simt_pc_unit.
// SIMT_PC_PERF_EN adds the diverge_count output.
interface simt_pc_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned THREADS     = 4,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned LW = $clog2(STACK_DEPTH + 1);

  logic [THREADS-1:0]            thread_enable;
  logic [2:0]                    core_state;
  logic [2:0]                    decoded_nzp;
  logic [PC_WIDTH-1:0]           decoded_immediate;
  logic                          decoded_nzp_write_enable;
  logic                          decoded_pc_mux;
  logic                          decoded_sync;
  logic [THREADS*DATA_WIDTH-1:0] alu_out;
  logic [PC_WIDTH-1:0]           current_pc;
  logic [PC_WIDTH-1:0]           next_pc;
  logic [THREADS-1:0]            active_mask;
  logic [LW-1:0]                 stack_level;
  logic                          stack_error;
`ifdef SIMT_PC_PERF_EN
  logic [15:0]                   diverge_count;
`endif

  modport master (
    output thread_enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_sync, alu_out, current_pc,
`ifdef SIMT_PC_PERF_EN
    input  diverge_count,
`endif
    input  next_pc, active_mask, stack_level, stack_error
  );

  modport slave (
    input  thread_enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_sync, alu_out, current_pc,
`ifdef SIMT_PC_PERF_EN
    output diverge_count,
`endif
    output next_pc, active_mask, stack_level, stack_error
  );
endinterface

// File: rtl/simt_pc_unit.sv
// Warp PC, per-lane NZP and reconvergence stack for divergent BRnzp.
// Define SIMT_PC_PERF_EN to add the saturating diverge_count output.
module simt_pc_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned THREADS     = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  simt_pc_if.slave     pc_if
);
  localparam int unsigned LW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] Execute = 3'b101;
  localparam logic [2:0] Update  = 3'b110;

  typedef enum logic {EntReconv = 1'b0, EntPath = 1'b1} entry_e;

  logic [PC_WIDTH-1:0] r_next_pc;
  logic [THREADS-1:0]  r_active_mask;
  logic [2:0]          r_nzp [THREADS];
  logic [LW-1:0]       r_level;
  logic                r_error;
  entry_e              r_stk_type [STACK_DEPTH];
  logic [PC_WIDTH-1:0] r_stk_pc   [STACK_DEPTH];
  logic [THREADS-1:0]  r_stk_mask [STACK_DEPTH];

  logic [THREADS-1:0]  w_eff;
  logic [THREADS-1:0]  w_taken;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [IW-1:0]       w_top_idx;
  logic [IW-1:0]       w_push_idx;
  logic [IW-1:0]       w_push_idx1;
  logic                w_can_push;
  logic                w_push;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic [THREADS-1:0]  w_mask;
  logic [LW-1:0]       w_level;
  logic                w_error;
  logic                w_unused_alu;

  assign w_eff        = r_active_mask & pc_if.thread_enable;
  assign w_pc_inc     = pc_if.current_pc + PC_WIDTH'(1);
  assign w_top_idx    = IW'(r_level - LW'(1));
  assign w_push_idx   = IW'(r_level);
  assign w_push_idx1  = IW'(r_level + LW'(1));
  assign w_can_push   = (r_level <= LW'(STACK_DEPTH - 2));
  assign w_unused_alu = ^pc_if.alu_out;

  always_comb begin
    w_taken = '0;
    for (int i = 0; i < THREADS; i++) begin
      w_taken[i] = w_eff[i] & (|(r_nzp[i] & pc_if.decoded_nzp));
    end
  end

  always_comb begin
    w_next_pc = r_next_pc;
    w_mask    = r_active_mask;
    w_level   = r_level;
    w_error   = r_error;
    w_push    = 1'b0;
    if (pc_if.core_state == Execute) begin
      w_next_pc = w_pc_inc;
      if (pc_if.decoded_sync) begin
        if (r_level == '0) begin
          w_error = 1'b1;
        end else begin
          w_level = r_level - LW'(1);
          w_mask  = r_stk_mask[w_top_idx];
          if (r_stk_type[w_top_idx] == EntPath) w_next_pc = r_stk_pc[w_top_idx];
        end
      end else if (pc_if.decoded_pc_mux) begin
        if (w_taken == w_eff) begin
          w_next_pc = pc_if.decoded_immediate;
        end else if (w_taken != '0) begin
          // Divergent: taken lanes run first, the rest wait on the PATH entry.
          w_next_pc = pc_if.decoded_immediate;
          if (w_can_push) begin
            w_push  = 1'b1;
            w_level = r_level + LW'(2);
            w_mask  = r_active_mask & ~(w_eff & ~w_taken);
          end else begin
            w_error = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_pc     <= '0;
      r_active_mask <= '1;
      r_level       <= '0;
      r_error       <= 1'b0;
      for (int i = 0; i < THREADS; i++) r_nzp[i] <= 3'b000;
    end else begin
      r_next_pc     <= w_next_pc;
      r_active_mask <= w_mask;
      r_level       <= w_level;
      r_error       <= w_error;
      if (pc_if.core_state == Update && pc_if.decoded_nzp_write_enable) begin
        for (int i = 0; i < THREADS; i++) begin
          if (w_eff[i]) r_nzp[i] <= pc_if.alu_out[i*DATA_WIDTH +: 3];
        end
      end
    end
  end

  // Stack contents need no reset; r_level alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_stk_type[w_push_idx]  <= EntReconv;
      r_stk_pc[w_push_idx]    <= w_pc_inc;
      r_stk_mask[w_push_idx]  <= r_active_mask;
      r_stk_type[w_push_idx1] <= EntPath;
      r_stk_pc[w_push_idx1]   <= w_pc_inc;
      r_stk_mask[w_push_idx1] <= r_active_mask & ~w_taken;
    end
  end

`ifdef SIMT_PC_PERF_EN
  logic [15:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_push && r_div_cnt != 16'hFFFF) begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  assign pc_if.diverge_count = r_div_cnt;
`endif

  assign pc_if.next_pc     = r_next_pc;
  assign pc_if.active_mask = r_active_mask;
  assign pc_if.stack_level = r_level;
  assign pc_if.stack_error = r_error;
endmodule

// File: tb/tb_simt_pc_unit.sv
// Scoreboard bench for simt_pc_unit: directed test-plan cases, then random instruction streams
// checked against a queue-based reference model.
module tb_simt_pc_unit;
  localparam int unsigned PW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned T     = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [2:0]  ST_EX = 3'b101;
  localparam logic [2:0]  ST_UP = 3'b110;

  logic clk = 1'b0;
  logic reset;

  simt_pc_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .THREADS(T), .STACK_DEPTH(DEPTH)) pif ();

  simt_pc_unit #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .THREADS(T), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .pc_if (pif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [3:0]  mask;
    logic [2:0]  lvl;
    logic        err;
`ifdef SIMT_PC_PERF_EN
    logic [15:0] cnt;
`endif
  } exp_t;

  typedef struct {
    bit         is_path;
    logic [7:0] pc;
    logic [3:0] mask;
  } ent_t;

  // Reference model state
  logic [7:0]  m_pc;
  logic [3:0]  m_mask;
  logic [2:0]  m_nzp [T];
  logic        m_err;
  logic [15:0] m_cnt;
  ent_t        m_stk [$];

  // Staged stimulus
  logic        s_reset;
  logic [2:0]  s_state;
  logic [3:0]  s_te;
  logic [2:0]  s_nzp;
  logic [7:0]  s_imm;
  logic        s_we, s_mux, s_sync;
  logic [31:0] s_alu;
  logic [7:0]  s_pc;

  exp_t exp_q [$];
  logic tb_expect = 1'b0;
  logic chk = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic model_step();
    logic [3:0] eff, taken;
    ent_t e;
    if (s_reset) begin
      m_pc = '0; m_mask = '1; m_err = 1'b0; m_cnt = '0;
      for (int i = 0; i < T; i++) m_nzp[i] = 3'b000;
      m_stk.delete();
    end else if (s_state == ST_EX) begin
      eff = m_mask & s_te;
      for (int i = 0; i < T; i++) taken[i] = eff[i] && ((m_nzp[i] & s_nzp) != 3'b000);
      if (s_sync) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_pc  = s_pc + 8'd1;
        end else begin
          e      = m_stk.pop_back();
          m_mask = e.mask;
          m_pc   = e.is_path ? e.pc : s_pc + 8'd1;
        end
      end else if (s_mux) begin
        if (taken == eff) m_pc = s_imm;
        else if (taken == 4'b0) m_pc = s_pc + 8'd1;
        else if (m_stk.size() + 2 <= DEPTH) begin
          m_stk.push_back('{is_path: 1'b0, pc: s_pc + 8'd1, mask: m_mask});
          m_stk.push_back('{is_path: 1'b1, pc: s_pc + 8'd1, mask: m_mask & ~taken});
          m_mask = m_mask & ~(eff & ~taken);
          m_pc   = s_imm;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          m_err = 1'b1;
          m_pc  = s_imm;
        end
      end else begin
        m_pc = s_pc + 8'd1;
      end
    end else if (s_state == ST_UP && s_we) begin
      for (int i = 0; i < T; i++) if (m_mask[i] && s_te[i]) m_nzp[i] = s_alu[i*8 +: 3];
    end
  endtask

  task automatic apply();
    exp_t x;
    @(posedge clk);
    #1;
    reset                         = s_reset;
    pif.thread_enable             = s_te;
    pif.core_state                = s_state;
    pif.decoded_nzp               = s_nzp;
    pif.decoded_immediate         = s_imm;
    pif.decoded_nzp_write_enable  = s_we;
    pif.decoded_pc_mux            = s_mux;
    pif.decoded_sync              = s_sync;
    pif.alu_out                   = s_alu;
    pif.current_pc                = s_pc;
    model_step();
    x.pc   = m_pc;
    x.mask = m_mask;
    x.lvl  = 3'(m_stk.size());
    x.err  = m_err;
`ifdef SIMT_PC_PERF_EN
    x.cnt  = m_cnt;
`endif
    exp_q.push_back(x);
    tb_expect = 1'b1;
  endtask

  task automatic clear_stage();
    s_reset = 1'b0; s_state = 3'b000; s_nzp = 3'b000; s_imm = '0;
    s_we = 1'b0; s_mux = 1'b0; s_sync = 1'b0; s_alu = '0; s_pc = '0;
  endtask

  task automatic do_reset(input logic [3:0] te);
    clear_stage(); s_reset = 1'b1; s_te = te; apply();
  endtask

  task automatic cmp4(input logic [2:0] l3, l2, l1, l0);
    clear_stage(); s_state = ST_UP; s_we = 1'b1;
    s_alu = {5'b0, l3, 5'b0, l2, 5'b0, l1, 5'b0, l0};
    apply();
  endtask

  task automatic ex_op(input logic [7:0] pc, input logic mux, input logic sync,
                       input logic [2:0] nzp, input logic [7:0] imm);
    clear_stage(); s_state = ST_EX; s_pc = pc; s_mux = mux; s_sync = sync;
    s_nzp = nzp; s_imm = imm;
    apply();
  endtask

  // Monitor: every cycle the driver issued produces one observable result a cycle later.
  always @(posedge clk) chk <= tb_expect;

  always @(negedge clk) begin
    exp_t e, got;
    if (chk) begin
      got.pc   = pif.next_pc;
      got.mask = pif.active_mask;
      got.lvl  = pif.stack_level;
      got.err  = pif.stack_error;
`ifdef SIMT_PC_PERF_EN
      got.cnt  = pif.diverge_count;
`endif
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underrun: output at %0t with no expectation queued", $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL vec%0d: got pc=%h mask=%h lvl=%0d err=%b, want pc=%h mask=%h lvl=%0d err=%b",
                   n_vec, got.pc, got.mask, got.lvl, got.err, e.pc, e.mask, e.lvl, e.err);
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1;
    pif.thread_enable = '1; pif.core_state = '0; pif.decoded_nzp = '0;
    pif.decoded_immediate = '0; pif.decoded_nzp_write_enable = 1'b0;
    pif.decoded_pc_mux = 1'b0; pif.decoded_sync = 1'b0; pif.alu_out = '0; pif.current_pc = '0;
    s_te = 4'hF;

    // Plain increment, uniform branch, divergence and reconvergence
    do_reset(4'hF);
    ex_op(8'h10, 1'b0, 1'b0, 3'b000, 8'h00);
    cmp4(3'b001, 3'b001, 3'b001, 3'b001);
    ex_op(8'h20, 1'b1, 1'b0, 3'b001, 8'h40);
    cmp4(3'b100, 3'b100, 3'b001, 3'b001);
    ex_op(8'h20, 1'b1, 1'b0, 3'b001, 8'h40);
    ex_op(8'h45, 1'b0, 1'b1, 3'b000, 8'h00);
    ex_op(8'h30, 1'b0, 1'b1, 3'b000, 8'h00);

    // Nest until the stack is full, then overflow and unwind
    cmp4(3'b100, 3'b001, 3'b001, 3'b001);
    ex_op(8'h20, 1'b1, 1'b0, 3'b001, 8'h40);
    cmp4(3'b001, 3'b100, 3'b001, 3'b001);
    ex_op(8'h40, 1'b1, 1'b0, 3'b001, 8'h50);
    cmp4(3'b001, 3'b001, 3'b100, 3'b001);
    ex_op(8'h50, 1'b1, 1'b1, 3'b001, 8'h60);
    ex_op(8'h50, 1'b1, 1'b0, 3'b001, 8'h60);
    for (int k = 0; k < 5; k++) ex_op(8'h70 + 8'(k), 1'b0, 1'b1, 3'b000, 8'h00);

    // Empty-stack SYNC with PC wrap
    do_reset(4'hF);
    ex_op(8'hFF, 1'b0, 1'b1, 3'b000, 8'h00);

    // Disabled lanes keep their NZP
    do_reset(4'b0011);
    cmp4(3'b100, 3'b100, 3'b001, 3'b001);
    ex_op(8'h08, 1'b1, 1'b0, 3'b100, 8'h80);
    ex_op(8'h09, 1'b1, 1'b0, 3'b001, 8'h80);

    // Random instruction streams
    do_reset(4'hF);
    for (int n = 0; n < 3000; n++) begin
      clear_stage();
      r = $urandom_range(0, 199);
      if (r < 3) begin
        s_reset = 1'b1;
        s_te = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      end else begin
        r = $urandom_range(0, 9);
        if (r < 5) s_state = ST_EX;
        else if (r < 8) s_state = ST_UP;
        else s_state = 3'($urandom_range(0, 4));
        s_pc  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : m_pc;
        s_nzp = 3'($urandom_range(0, 7));
        s_imm = 8'($urandom);
        s_we  = 1'($urandom_range(0, 1));
        s_alu = $urandom;
        r = $urandom_range(0, 19);
        s_mux  = (r < 9);
        s_sync = (r >= 8 && r < 14);
      end
      apply();
    end

    @(posedge clk); #1;
    tb_expect = 1'b0;
    clear_stage();
    pif.core_state = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/simt_pc_unit.md
Name: simt_pc_unit

Overview:
- Per-block program-counter and branch unit for the SIMT core.
- Generalises the single-thread PC/NZP logic to THREADS lanes. Each lane keeps its own NZP register.
- One shared warp PC plus an active mask; a reconvergence stack handles divergent BRnzp.
- Sits between decoder/ALUs and the fetch scheduler; the scheduler feeds next_pc back as current_pc.

Parameters:
- PC_WIDTH, 8, width of PC and branch immediate
- DATA_WIDTH, 8, per-lane ALU result width (>=3)
- THREADS, 4, lanes per block
- STACK_DEPTH, 4, reconvergence stack entries (even, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- thread_enable  in  THREADS  lanes populated in current block; static while block runs
- core_state  in  3  core FSM state; EXECUTE=3'b101, UPDATE=3'b110
- decoded_nzp  in  3  branch condition mask {n,z,p}
- decoded_immediate  in  PC_WIDTH  branch target
- decoded_nzp_write_enable  in  1  CMP result write (UPDATE)
- decoded_pc_mux  in  1  1 = BRnzp instruction
- decoded_sync  in  1  1 = SYNC instruction (reconvergence point)
- alu_out  in  THREADS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- current_pc  in  PC_WIDTH  PC of instruction in flight
- next_pc  out  PC_WIDTH  registered next warp PC
- active_mask  out  THREADS  registered lanes currently executing
- stack_level  out  clog2(STACK_DEPTH+1)  occupied entries
- stack_error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset: next_pc=0, active_mask=all ones, all nzp=0, stack_level=0, stack_error=0, stack contents don't-care.
- Effective mask: eff = active_mask & thread_enable. Lanes outside eff never update NZP.
- UPDATE, nzp_write_enable=1: nzp[i] <= alu_out lane i bits [2:0] for each lane in eff.
- EXECUTE: actions are evaluated once per instruction, with 1-cycle latency to next_pc/active_mask.
- Default EXECUTE action (no branch, no sync): next_pc=current_pc+1, modulo 2^PC_WIDTH wrap.
- BRnzp: taken[i] = eff[i] & |(nzp[i] & decoded_nzp).
  - taken==eff (includes eff==0): next_pc=imm; mask unchanged.
  - taken==0, eff!=0: next_pc=current_pc+1; mask unchanged.
  - otherwise divergent, needs 2 free entries:
    - push RECONV{mask=active_mask}, then PATH{pc=current_pc+1, mask=active_mask & ~taken}
    - active_mask <= active_mask & ~(eff & ~taken); next_pc=imm; stack_level += 2
- Divergent with fewer than 2 free entries:
  - no push; stack_error<=1
  - branch resolved uniformly: next_pc=imm if taken!=0, else current_pc+1
- SYNC with stack non-empty: pop top.
  - PATH: active_mask<=entry.mask, next_pc<=entry.pc.
  - RECONV: active_mask<=entry.mask, next_pc<=current_pc+1.
- SYNC with stack empty: stack_error<=1; next_pc=current_pc+1.
- decoded_pc_mux and decoded_sync both 1: SYNC wins.
- Each entry carries a 1-bit type plus PC_WIDTH pc plus THREADS mask.
- stack_error clears only on reset.
- Reset mid-divergence discards the stack and restores the full mask.
- States other than EXECUTE/UPDATE: no register changes.

Optional Feature:
- Macro SIMT_PC_PERF_EN.
- Defined: adds output diverge_count[15:0]. Reset 0; +1 per successful divergent push; saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then EXECUTE with current_pc=8'h10, no branch -> next_pc=8'h11, active_mask=4'hF, stack_level=0.
- All lanes CMP alu_out[2:0]=3'b001, then BRnzp nzp=3'b001 imm=8'h40 at pc 8'h20 -> next_pc=8'h40, mask 4'hF, no push.
- Lanes 0,1 nzp=001 and lanes 2,3 nzp=100; BRnzp p imm=8'h40 at pc 8'h20 -> next_pc=8'h40, mask 4'h3, level=2.
  - Then SYNC at 8'h45 -> next_pc=8'h21, mask 4'hC, level=1.
  - Then SYNC at 8'h30 -> next_pc=8'h31, mask 4'hF, level=0.
- STACK_DEPTH=2: nested divergent branch while level=2 -> stack_error=1, no push, uniform branch taken to imm.
- SYNC with empty stack at pc 8'hFF -> next_pc=8'h00 (wrap), stack_error=1.
- thread_enable=4'b0011, lanes 2,3 fed alu_out 3'b100 during CMP -> their nzp stay 0. BRnzp n -> next_pc=pc+1, no divergence.
